// File: rtl/xnor_conv_mc.sv
// xnor_conv_mc: multi-kernel binary 3x3 XNOR-popcount convolution engine.
// Streams bit-packed rows, writes one thresholded word per kernel per row.
// Ports:
//   clk, reset_b             clock, async active-low reset
//   dut_run / dut_busy       start request / run in progress
//   dut_sram_read_address    input row/header address (1-cycle latency)
//   sram_dut_read_data       input data for previous cycle's address
//   dut_sram_write_*         output word address, data, strobe
//   dut_wmem_read_address    weight address (1-cycle latency)
//   wmem_dut_read_data       weight word, kernel k at address k, bits[8:0]
module xnor_conv_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int NUM_K  = 2,
  parameter int THRESH = 5
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LDW  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_CONV = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [2:0] K_LAST = 3'(NUM_K - 1);
  localparam logic [3:0] LW_END = 4'(NUM_K);
  localparam logic [8:0] N_MAX  = 9'(DATA_W);
  localparam logic [3:0] THR    = 4'(THRESH);
  localparam logic [DATA_W-1:0] TERM = DATA_W'(255);

  logic [2:0]        state;
  logic              hdr_ph;
  logic              fill_ph;
  logic [3:0]        lw_cnt;
  logic [2:0]        k;
  logic [7:0]        n_reg;
  logic [7:0]        rows_left;
  logic [DATA_W-1:0] w0;
  logic [DATA_W-1:0] w1;
  logic [DATA_W-1:0] w2;
  logic [8:0]        wt [8];
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wm_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] out_cnt;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              busy;

  logic [7:0]        hdr_n;
  logic              hdr_term;
  logic              hdr_ok;
  logic [DATA_W-1:0] row2;
  logic [8:0]        wsel;
  logic [DATA_W-1:0] conv_bits;
  logic [DATA_W-1:0] col_mask;
  logic              unused_wm;

  function automatic logic [3:0] pop9(
    input logic [8:0] v
  );
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 9; i++)
      s = s + {3'd0, v[i]};
    return s;
  endfunction

  assign hdr_n    = sram_dut_read_data[7:0];
  assign hdr_term = sram_dut_read_data == TERM;
  assign hdr_ok   = ({1'b0, hdr_n} >= 9'd3) &&
                    ({1'b0, hdr_n} <= N_MAX);

  // Newest row comes straight off the bus on the first
  // kernel of each row and is held in w2 for the rest.
  assign row2 = (k == 3'd0) ? sram_dut_read_data : w2;
  assign wsel = wt[k];

  assign unused_wm = ^wmem_dut_read_data[DATA_W-1:9];

  always_comb begin
    conv_bits = '0;
    col_mask  = '0;
    for (int c = 0; c < DATA_W - 2; c++) begin
      conv_bits[c] = pop9(~(wsel ^ {row2[c+:3],
                                    w1[c+:3],
                                    w0[c+:3]})) >= THR;
      col_mask[c]  = (9'(c) + 9'd2) < {1'b0, n_reg};
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state     <= S_IDLE;
      hdr_ph    <= 1'b0;
      fill_ph   <= 1'b0;
      lw_cnt    <= '0;
      k         <= '0;
      n_reg     <= '0;
      rows_left <= '0;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      for (int i = 0; i < 8; i++)
        wt[i] <= '0;
      rd_addr   <= '0;
      wm_addr   <= '0;
      wr_addr   <= '0;
      out_cnt   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (dut_run) begin
            state   <= S_LDW;
            busy    <= 1'b1;
            lw_cnt  <= '0;
            wm_addr <= '0;
            rd_addr <= '0;
            out_cnt <= '0;
          end
        end
        S_LDW: begin
          if (lw_cnt != 4'd0)
            wt[lw_cnt[2:0] - 3'd1] <=
              wmem_dut_read_data[8:0];
          if (lw_cnt + 4'd1 < LW_END)
            wm_addr <= wm_addr + 1'b1;
          lw_cnt <= lw_cnt + 4'd1;
          if (lw_cnt == LW_END) begin
            state  <= S_HDR;
            hdr_ph <= 1'b0;
          end
        end
        S_HDR: begin
          if (!hdr_ph) begin
            // header address on the bus; move on to row 0
            rd_addr <= rd_addr + 1'b1;
            hdr_ph  <= 1'b1;
          end else begin
            hdr_ph <= 1'b0;
            if (hdr_term) begin
              state <= S_DONE;
            end else if (hdr_ok) begin
              n_reg     <= hdr_n;
              rows_left <= hdr_n - 8'd2;
              rd_addr   <= rd_addr + 1'b1;
              fill_ph   <= 1'b0;
              state     <= S_FILL;
            end else begin
              // rd_addr already points at header+1
              rd_addr <= rd_addr + ADDR_W'(hdr_n);
            end
          end
        end
        S_FILL: begin
          rd_addr <= rd_addr + 1'b1;
          if (!fill_ph) begin
            w0      <= sram_dut_read_data;
            fill_ph <= 1'b1;
          end else begin
            w1    <= sram_dut_read_data;
            k     <= '0;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          wr_en   <= 1'b1;
          wr_addr <= out_cnt;
          wr_data <= conv_bits & col_mask;
          out_cnt <= out_cnt + 1'b1;
          if (k == 3'd0)
            w2 <= sram_dut_read_data;
          if (k == K_LAST) begin
            k <= '0;
            if (rows_left == 8'd1) begin
              // rd_addr now sits on the next header
              state  <= S_HDR;
              hdr_ph <= 1'b0;
            end else begin
              rows_left <= rows_left - 8'd1;
              w0        <= w1;
              w1        <= row2;
              rd_addr   <= rd_addr + 1'b1;
            end
          end else begin
            k <= k + 3'd1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign dut_busy               = busy;
  assign dut_sram_read_address  = rd_addr;
  assign dut_sram_write_address = wr_addr;
  assign dut_sram_write_data    = wr_data;
  assign dut_sram_write_enable  = wr_en;
  assign dut_wmem_read_address  = wm_addr;

endmodule
